// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  localparam int unsigned REG_W          = 5;
  localparam int unsigned DIV_CYCLES_DEF = 32;

  typedef enum logic {
    RUN      = 1'b0,
    DIV_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/hazard_stats.sv
// Stall and flush event counters; both wrap modulo 2^CNT_W.
module hazard_stats #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_en,
  input  logic             ifid_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_en)     stall_cnt <= stall_cnt + CNT_W'(1);
      if (ifid_flush) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch squash, divider occupancy.
// Optional statistics counters are built when HAZ_STATS_EN is defined.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_is_div,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_branch_taken,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             div_busy
`ifdef HAZ_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam int unsigned DL_W = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;

  // Elaboration-time parameter sanity checks.
  if (DIV_CYCLES < 2) begin : g_bad_div_cycles
    $error("hazard_ctrl: DIV_CYCLES must be at least 2");
  end
  if (CNT_W == 0) begin : g_bad_cnt_w
    $error("hazard_ctrl: CNT_W must be non-zero");
  end

  state_t          state, state_nxt;
  logic [DL_W-1:0] div_left, div_left_nxt;
  logic            load_use;

  assign load_use = ex_memread && (ex_rt != '0) &&
                    ((id_uses_rs && (id_rs == ex_rt)) ||
                     (id_uses_rt && (id_rt == ex_rt)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      div_left <= '0;
    end else begin
      state    <= state_nxt;
      div_left <= div_left_nxt;
    end
  end

  // Next state and control outputs; in DIV_WAIT the EX instruction is the divide,
  // so branch and load-use inputs do not apply.
  always_comb begin
    state_nxt    = state;
    div_left_nxt = div_left;
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    div_busy     = 1'b0;
    case (state)
      RUN: begin
        if (ex_branch_taken) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (load_use) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
        end else if (id_is_div) begin
          state_nxt    = DIV_WAIT;
          div_left_nxt = DL_W'(DIV_CYCLES - 1);
        end
      end
      DIV_WAIT: begin
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        div_busy     = 1'b1;
        div_left_nxt = div_left - DL_W'(1);
        if (div_left == DL_W'(1)) state_nxt = RUN;
      end
      default: ;
    endcase
  end

`ifdef HAZ_STATS_EN
  hazard_stats #(
    .CNT_W(CNT_W)
  ) u_stats (
    .clk       (clk),
    .rst       (rst),
    .pc_en     (pc_en),
    .ifid_flush(ifid_flush),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl with DIV_CYCLES=4; counters checked when HAZ_STATS_EN is defined.
module tb_hazard_ctrl;

  localparam int unsigned DIV_CYCLES = 4;
  localparam int unsigned CNT_W      = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rs, id_uses_rt, id_is_div, ex_memread, ex_branch_taken;
  logic       pc_en, ifid_en, ifid_flush, idex_bubble, div_busy;
`ifdef HAZ_STATS_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .DIV_CYCLES(DIV_CYCLES),
    .CNT_W     (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_uses_rs     (id_uses_rs),
    .id_uses_rt     (id_uses_rt),
    .id_is_div      (id_is_div),
    .ex_memread     (ex_memread),
    .ex_rt          (ex_rt),
    .ex_branch_taken(ex_branch_taken),
    .pc_en          (pc_en),
    .ifid_en        (ifid_en),
    .ifid_flush     (ifid_flush),
    .idex_bubble    (idex_bubble),
    .div_busy       (div_busy)
`ifdef HAZ_STATS_EN
    ,
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic div,
                       input logic mr, input logic [4:0] xrt, input logic br);
    id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_is_div = div; ex_memread = mr; ex_rt = xrt; ex_branch_taken = br;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  // One cycle: sample outputs on the falling edge, then advance past the rising edge.
  task automatic step(input string tag, input logic e_pc, input logic e_ifid,
                      input logic e_fl, input logic e_bub, input logic e_busy);
    @(negedge clk);
    chk({tag, ".pc_en"},       32'(pc_en),       32'(e_pc));
    chk({tag, ".ifid_en"},     32'(ifid_en),     32'(e_ifid));
    chk({tag, ".ifid_flush"},  32'(ifid_flush),  32'(e_fl));
    chk({tag, ".idex_bubble"}, 32'(idex_bubble), 32'(e_bub));
    chk({tag, ".div_busy"},    32'(div_busy),    32'(e_busy));
`ifdef HAZ_STATS_EN
    chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(exp_stall));
    chk({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(exp_flush));
`endif
    if (rst) begin
      exp_stall = 0;
      exp_flush = 0;
    end else begin
      if (!e_pc) exp_stall++;
      if (e_fl)  exp_flush++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    step("reset_idle", 1, 1, 0, 0, 0);

    drive(5'd8, 5'd0, 1, 0, 0, 1, 5'd8, 0);
    step("lu_rs", 0, 0, 0, 1, 0);
    idle();
    step("lu_after", 1, 1, 0, 0, 0);

    drive(5'd3, 5'd5, 0, 1, 0, 1, 5'd5, 0);
    step("lu_rt", 0, 0, 0, 1, 0);
    drive(5'd3, 5'd5, 1, 0, 0, 1, 5'd5, 0);
    step("rt_unused", 1, 1, 0, 0, 0);
    drive(5'd0, 5'd0, 1, 1, 0, 1, 5'd0, 0);
    step("ex_rt_zero", 1, 1, 0, 0, 0);
    drive(5'd8, 5'd0, 1, 0, 0, 0, 5'd8, 0);
    step("no_load", 1, 1, 0, 0, 0);

    // Branch outranks load-use and a divide in ID; no DIV_WAIT follows.
    drive(5'd8, 5'd0, 1, 0, 1, 1, 5'd8, 1);
    step("br_over_lu", 1, 1, 1, 1, 0);
    idle();
    step("br_after", 1, 1, 0, 0, 0);

    // Divide, with a second divide waiting in ID; hazards ignored while busy.
    drive(5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0);
    step("div_issue", 1, 1, 0, 0, 0);
    drive(5'd8, 5'd0, 1, 0, 1, 1, 5'd8, 1);
    step("div_w1", 0, 0, 0, 0, 1);
    step("div_w2", 0, 0, 0, 0, 1);
    step("div_w3", 0, 0, 0, 0, 1);
    drive(5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0);
    step("div2_issue", 1, 1, 0, 0, 0);
    step("div2_w1", 0, 0, 0, 0, 1);

    // Reset during the second DIV_WAIT cycle.
    rst = 1'b1;
    step("div2_rst", 0, 0, 0, 0, 1);
    rst = 1'b0;
    idle();
    step("post_rst", 1, 1, 0, 0, 0);

    // Load-use arriving on the first RUN cycle after a divide.
    drive(5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0);
    step("div3_issue", 1, 1, 0, 0, 0);
    idle();
    step("div3_w1", 0, 0, 0, 0, 1);
    step("div3_w2", 0, 0, 0, 0, 1);
    step("div3_w3", 0, 0, 0, 0, 1);
    drive(5'd7, 5'd9, 1, 1, 0, 1, 5'd9, 0);
    step("lu_at_exit", 0, 0, 0, 1, 0);
    idle();
    step("final", 1, 1, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
